// File: rtl/rgb_color_decoder.sv
// rtl/rgb_color_decoder.sv - RGB LED pin decoder with deglitch, dwell timing and colour-wheel check; option macro RGB_DECODER_REVERSE_EN
module rgb_color_decoder #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int DWELL_W       = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rgb_r_n,
   input  logic               rgb_g_n,
   input  logic               rgb_b_n,
   output logic [2:0]         color,
   output logic               color_valid,
   output logic               change_pulse,
   output logic [DWELL_W-1:0] dwell_count,
   output logic               seq_error,
   output logic               err_sticky
);

   localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic {ST_INIT, ST_TRACK} state_t;

   logic [2:0]         sync_q [SYNC_STAGES];
   logic [2:0]         raw;
   logic [2:0]         candidate;
   logic [CNT_W-1:0]   stable_cnt;
   logic [DWELL_W-1:0] run_cnt;
   logic [DWELL_W-1:0] run_next;
   state_t             state;
   logic               accept;
   logic               step_ok;

   // Next colour on the wheel; 000 marks "no legal successor" (off/white)
   function automatic logic [2:0] wheel_next(input logic [2:0] c);
      case (c)
         3'b100:  return 3'b110;
         3'b110:  return 3'b010;
         3'b010:  return 3'b011;
         3'b011:  return 3'b001;
         3'b001:  return 3'b101;
         3'b101:  return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   // Previous colour on the wheel; 000 marks "no legal predecessor"
   function automatic logic [2:0] wheel_prev(input logic [2:0] c);
      case (c)
         3'b100:  return 3'b101;
         3'b110:  return 3'b100;
         3'b010:  return 3'b110;
         3'b011:  return 3'b010;
         3'b001:  return 3'b011;
         3'b101:  return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   assign raw    = ~sync_q[SYNC_STAGES-1];
   assign accept = (stable_cnt == CNT_MAX) && (candidate != color);

   // run counter +1 also gives the dwell value; it never wraps
   assign run_next = (&run_cnt) ? run_cnt : run_cnt + 1'b1;

`ifdef RGB_DECODER_REVERSE_EN
   assign step_ok = ((wheel_next(color) != 3'b000) && (candidate == wheel_next(color))) ||
                    ((wheel_prev(color) != 3'b000) && (candidate == wheel_prev(color)));
`else
   assign step_ok = (wheel_next(color) != 3'b000) && (candidate == wheel_next(color));
`endif

   // Pin synchroniser; idle (LED off) is all ones on the active-low pins
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b111;
      end else begin
         sync_q[0] <= {rgb_r_n, rgb_g_n, rgb_b_n};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // Deglitch filter: a new value must be seen STABLE_CYCLES times in a row
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         candidate  <= 3'b000;
         stable_cnt <= '0;
      end else if (raw != candidate) begin
         candidate  <= raw;
         stable_cnt <= '0;
      end else if (stable_cnt != CNT_MAX) begin
         stable_cnt <= stable_cnt + 1'b1;
      end
   end

   // Cycles since the last accepted colour change
   always_ff @(posedge clk) begin
      if (!rst_n)      run_cnt <= '0;
      else if (accept) run_cnt <= '0;
      else             run_cnt <= run_next;
   end

   // Tracking FSM with registered colour, dwell and sequence-error outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_INIT;
         color        <= 3'b000;
         color_valid  <= 1'b0;
         change_pulse <= 1'b0;
         dwell_count  <= '0;
         seq_error    <= 1'b0;
         err_sticky   <= 1'b0;
      end else begin
         change_pulse <= accept;
         seq_error    <= 1'b0;
         if (accept) begin
            color <= candidate;
            case (state)
               ST_INIT: begin
                  state       <= ST_TRACK;
                  color_valid <= 1'b1;
               end
               ST_TRACK: begin
                  dwell_count <= run_next;
                  if (!step_ok) begin
                     seq_error  <= 1'b1;
                     err_sticky <= 1'b1;
                  end
               end
               default: state <= ST_INIT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rgb_color_decoder.sv
// tb/tb_rgb_color_decoder.sv - self-checking bench for rgb_color_decoder
module tb_rgb_color_decoder;

   localparam int LAT    = 6;
   localparam int STABLE = 4;

   localparam logic [2:0] C_R = 3'b100, C_Y = 3'b110, C_G = 3'b010;
   localparam logic [2:0] C_C = 3'b011, C_B = 3'b001, C_M = 3'b101;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rgb_r_n = 1'b1, rgb_g_n = 1'b1, rgb_b_n = 1'b1;
   logic [2:0]  color;
   logic        color_valid, change_pulse, seq_error, err_sticky;
   logic [31:0] dwell_count;

   int checks = 0;
   int failures = 0;
   int ecnt = 0;

   typedef struct {
      int          edge_no;
      logic [2:0]  col;
      logic [31:0] dwell;
      logic        err;
   } ev_t;

   ev_t        evq[$];
   logic [2:0] seg_col[$];
   int         seg_len[$];

   // generation-side model state
   logic [2:0] gen_cur;
   logic       gen_valid;
   int         gen_last;
   logic [2:0] last_pin;

   // checking-side expected outputs
   logic [2:0]  exp_color;
   logic        exp_valid, exp_sticky;
   logic [31:0] exp_dwell;

   rgb_color_decoder dut (
      .clk(clk), .rst_n(rst_n),
      .rgb_r_n(rgb_r_n), .rgb_g_n(rgb_g_n), .rgb_b_n(rgb_b_n),
      .color(color), .color_valid(color_valid), .change_pulse(change_pulse),
      .dwell_count(dwell_count), .seq_error(seq_error), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;
   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, ecnt);
      end
   endtask

   // A step is legal only when the new colour is the wheel neighbour of the old one
   function automatic bit legal(input logic [2:0] o, input logic [2:0] n);
      logic [2:0] w[6];
      w = '{C_R, C_Y, C_G, C_C, C_B, C_M};
      for (int i = 0; i < 6; i++) begin
         if (w[i] == o) begin
            if (w[(i + 1) % 6] == n) return 1'b1;
`ifdef RGB_DECODER_REVERSE_EN
            if (w[(i + 5) % 6] == n) return 1'b1;
`endif
         end
      end
      return 1'b0;
   endfunction

   task automatic add(input logic [2:0] c, input int len);
      seg_col.push_back(c);
      seg_len.push_back(len);
      last_pin = c;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      {rgb_r_n, rgb_g_n, rgb_b_n} = 3'b111;
      repeat (3) begin
         @(posedge clk); #1;
         chk("rst_color", 32'(color), 0);
         chk("rst_valid", 32'(color_valid), 0);
         chk("rst_pulse", 32'(change_pulse), 0);
         chk("rst_seqerr", 32'(seq_error), 0);
         chk("rst_sticky", 32'(err_sticky), 0);
         chk("rst_dwell", dwell_count, 0);
      end
      rst_n = 1'b1;
      gen_cur = 3'b000; gen_valid = 1'b0; gen_last = 0; last_pin = 3'b000;
      exp_color = 3'b000; exp_valid = 1'b0; exp_sticky = 1'b0; exp_dwell = 0;
      evq.delete();
   endtask

   // Expand the queued segments into pin values, predict events, then drive and check every cycle
   task automatic play();
      logic [2:0] pins[$];
      int         off;
      ev_t        ev;
      logic       exp_pulse, exp_err;
      off = 0;
      seg_len[seg_len.size() - 1] += 8;
      foreach (seg_col[i]) begin
         if (seg_len[i] >= STABLE && seg_col[i] != gen_cur) begin
            ev.edge_no = ecnt + off + 1 + LAT;
            ev.col     = seg_col[i];
            ev.dwell   = 32'(ev.edge_no - gen_last);
            ev.err     = gen_valid && !legal(gen_cur, seg_col[i]);
            evq.push_back(ev);
            gen_valid = 1'b1;
            gen_last  = ev.edge_no;
            gen_cur   = seg_col[i];
         end
         repeat (seg_len[i]) pins.push_back(seg_col[i]);
         off += seg_len[i];
      end
      seg_col.delete();
      seg_len.delete();
      foreach (pins[k]) begin
         @(negedge clk);
         {rgb_r_n, rgb_g_n, rgb_b_n} = ~pins[k];
         @(posedge clk); #1;
         exp_pulse = 1'b0;
         exp_err   = 1'b0;
         if (evq.size() > 0 && evq[0].edge_no == ecnt) begin
            ev = evq.pop_front();
            exp_pulse = 1'b1;
            if (exp_valid) exp_dwell = ev.dwell;
            exp_err    = ev.err;
            exp_sticky = exp_sticky | ev.err;
            exp_valid  = 1'b1;
            exp_color  = ev.col;
         end
         chk("pulse", 32'(change_pulse), 32'(exp_pulse));
         chk("seq_error", 32'(seq_error), 32'(exp_err));
         chk("color", 32'(color), 32'(exp_color));
         chk("color_valid", 32'(color_valid), 32'(exp_valid));
         chk("err_sticky", 32'(err_sticky), 32'(exp_sticky));
         chk("dwell", dwell_count, exp_dwell);
      end
      chk("events_drained", 32'(evq.size()), 0);
   endtask

   initial begin
      logic [2:0] c;
      // reset state
      do_reset();

      // first colour, full wheel at 100 cycles each, a short glitch, then an illegal jump
      add(C_R, 200);
      add(C_Y, 100); add(C_G, 100); add(C_C, 100);
      add(C_B, 100); add(C_M, 100); add(C_R, 100);
      add(C_Y, 2);   add(C_R, 60);
      add(C_G, 100);
      play();
      chk("sticky_after_illegal", 32'(err_sticky), 1);

      // random segments mixing glitches and long holds
      for (int n = 0; n < 40; n++) begin
         do c = 3'($urandom_range(0, 7)); while (c == last_pin);
         if ($urandom_range(0, 2) == 0) add(c, $urandom_range(1, STABLE - 1));
         else                           add(c, $urandom_range(STABLE, 40));
      end
      do c = 3'($urandom_range(0, 7)); while (c == last_pin);
      add(c, 30);
      play();

      // sticky clears on reset; red to magenta depends on the reverse option
      do_reset();
      add(C_R, 100);
      add(C_M, 100);
      play();
`ifdef RGB_DECODER_REVERSE_EN
      chk("reverse_sticky", 32'(err_sticky), 0);
`else
      chk("reverse_sticky", 32'(err_sticky), 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
